// File: rtl/mem_access_ctrl.sv
// Sub-word load/store controller in front of a word-wide, combinational-read DataMemory.
// Latency: load / word store respond 2 edges after accept, sub-word store (RMW) 3, faults 1.
// Backpressure: busy is high outside IDLE; requests seen while busy are dropped, not queued.
//
// Ports:
//   clk, rst                      clock and asynchronous active-high reset
//   req_valid/_write/_size/...    request from the datapath (sampled only when busy=0)
//   busy                          stall to the core
//   resp_valid/resp_rdata         one-cycle completion pulse and extended load data
//   misaligned                    one-cycle fault pulse, coincident with resp_valid
//   mem_addr/_wdata/_read/_write  DataMemory controls; mem_rdata is its combinational output
module mem_access_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        busy,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        misaligned,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_STORE,
        ST_RMW_RD,
        ST_RMW_WR
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  size_q, size_d;
    logic        unsigned_q, unsigned_d;
    logic [31:0] merged_q, merged_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_valid_q, resp_valid_d;
    logic        misaligned_q, misaligned_d;

    logic        req_fault;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] load_ext;
    logic [31:0] merged_word;

    // Alignment check on the incoming request; size 11 is never legal.
    always_comb begin
        req_fault = 1'b0;
        case (req_size)
            SZ_BYTE: req_fault = 1'b0;
            SZ_HALF: req_fault = req_addr[0];
            SZ_WORD: req_fault = (req_addr[1:0] != 2'b00);
            default: req_fault = 1'b1;
        endcase
    end

    // Little-endian lane extraction and sign/zero extension of the read word.
    always_comb begin
        byte_lane = 8'h00;
        case (addr_q[1:0])
            2'd0:    byte_lane = mem_rdata[7:0];
            2'd1:    byte_lane = mem_rdata[15:8];
            2'd2:    byte_lane = mem_rdata[23:16];
            default: byte_lane = mem_rdata[31:24];
        endcase
        half_lane = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (size_q)
            SZ_BYTE: load_ext = {{24{~unsigned_q & byte_lane[7]}}, byte_lane};
            SZ_HALF: load_ext = {{16{~unsigned_q & half_lane[15]}}, half_lane};
            default: load_ext = mem_rdata;
        endcase
    end

    // Read word with the target lane replaced by the low store bits.
    always_comb begin
        merged_word = mem_rdata;
        if (size_q == SZ_BYTE) begin
            case (addr_q[1:0])
                2'd0:    merged_word[7:0]   = wdata_q[7:0];
                2'd1:    merged_word[15:8]  = wdata_q[7:0];
                2'd2:    merged_word[23:16] = wdata_q[7:0];
                default: merged_word[31:24] = wdata_q[7:0];
            endcase
        end else if (addr_q[1]) begin
            merged_word[31:16] = wdata_q[15:0];
        end else begin
            merged_word[15:0] = wdata_q[15:0];
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        size_d       = size_q;
        unsigned_d   = unsigned_q;
        merged_d     = merged_q;
        resp_rdata_d = resp_rdata_q;
        resp_valid_d = 1'b0;
        misaligned_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d     = req_addr;
                    wdata_d    = req_wdata;
                    size_d     = req_size;
                    unsigned_d = req_unsigned;
                    if (req_fault) begin
                        // Faults complete from IDLE without touching memory.
                        resp_valid_d = 1'b1;
                        misaligned_d = 1'b1;
                    end else if (!req_write) begin
                        state_d = ST_LOAD;
                    end else if (req_size == SZ_WORD) begin
                        state_d = ST_STORE;
                    end else begin
                        state_d = ST_RMW_RD;
                    end
                end
            end
            ST_LOAD: begin
                resp_rdata_d = load_ext;
                resp_valid_d = 1'b1;
                state_d      = ST_IDLE;
            end
            ST_STORE: begin
                resp_valid_d = 1'b1;
                state_d      = ST_IDLE;
            end
            ST_RMW_RD: begin
                merged_d = merged_word;
                state_d  = ST_RMW_WR;
            end
            ST_RMW_WR: begin
                resp_valid_d = 1'b1;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            size_q       <= 2'b00;
            unsigned_q   <= 1'b0;
            merged_q     <= 32'h0;
            resp_rdata_q <= 32'h0;
            resp_valid_q <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            size_q       <= size_d;
            unsigned_q   <= unsigned_d;
            merged_q     <= merged_d;
            resp_rdata_q <= resp_rdata_d;
            resp_valid_q <= resp_valid_d;
            misaligned_q <= misaligned_d;
        end
    end

    // Memory strobes decode from state alone, so an async reset drops them at once.
    always_comb begin
        busy      = (state_q != ST_IDLE);
        mem_read  = (state_q == ST_LOAD) || (state_q == ST_RMW_RD);
        mem_write = (state_q == ST_STORE) || (state_q == ST_RMW_WR);
        mem_addr  = {addr_q[31:2], 2'b00};
        case (state_q)
            ST_STORE:  mem_wdata = wdata_q;
            ST_RMW_WR: mem_wdata = merged_q;
            default:   mem_wdata = 32'h0;
        endcase
    end

    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign misaligned = misaligned_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed scenarios then random requests,
// compared against a byte-array memory model. Includes a simple DataMemory model.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_write, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        busy, resp_valid, misaligned, mem_read, mem_write;
    logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] env_mem [0:15] = '{default: 32'h0};
    logic [7:0]  ref_mem [0:63] = '{default: 8'h0};
    logic [31:0] exp_rdata;
    logic [31:0] got;

    always #5 clk = ~clk;

    mem_access_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .busy         (busy),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .misaligned   (misaligned),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_rdata    (mem_rdata)
    );

    // DataMemory stand-in: combinational read, write at the rising edge.
    assign mem_rdata = env_mem[mem_addr[5:2]];
    always @(posedge clk) if (mem_write) env_mem[mem_addr[5:2]] <= mem_wdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit is_fault(input logic [1:0] sz, input logic [31:0] a);
        return (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0);
    endfunction

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] sz, input bit uns, input logic [31:0] a);
        logic [31:0] v = 32'h0;
        int n = nbytes(sz);
        for (int i = 0; i < n; i++) v = v | (32'(ref_mem[a + i]) << (8 * i));
        if (!uns && n == 1 && v >= 32'd128)   v = v | 32'hFFFFFF00;
        if (!uns && n == 2 && v >= 32'd32768) v = v | 32'hFFFF0000;
        return v;
    endfunction

    task automatic model_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        int n = nbytes(sz);
        for (int i = 0; i < n; i++) ref_mem[a + i] = 8'(wd >> (8 * i));
    endtask

    function automatic logic [31:0] ref_word(input int w);
        return {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]};
    endfunction

    // Issue one request from IDLE and follow it to its response.
    task automatic do_op(input bit wr, input logic [1:0] sz, input bit uns,
                         input logic [31:0] a, input logic [31:0] wd, input bit stall,
                         output logic [31:0] rd);
        bit          flt = is_fault(sz, a);
        int          exp_lat, exp_rd, exp_wr;
        int          lat = 0, nbusy = 0, nrd = 0, nwr = 0;
        logic [31:0] exp_load = 32'h0;
        exp_lat = flt ? 1 : (wr && sz != 2'd2) ? 3 : 2;
        exp_rd  = flt ? 0 : (wr && sz == 2'd2) ? 0 : 1;
        exp_wr  = (!flt && wr) ? 1 : 0;
        if (!flt && !wr) exp_load = model_load(sz, uns, a);

        req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd;
        #1;
        chk("busy_before_accept", 32'(busy), 32'h0);
        @(posedge clk); #1;
        if (stall && !flt) begin
            // Different request held high while busy; must be ignored.
            req_valid = 1'b1; req_write = ~wr; req_size = 2'($urandom_range(0, 3));
            req_unsigned = ~uns; req_addr = $urandom; req_wdata = $urandom;
        end else begin
            req_valid = 1'b0;
        end
        for (int c = 1; c <= 6 && lat == 0; c++) begin
            @(negedge clk);
            if (busy)      nbusy++;
            if (mem_read)  nrd++;
            if (mem_write) nwr++;
            chk("rd_wr_exclusive", 32'(mem_read & mem_write), 32'h0);
            if (mem_read || mem_write) chk("mem_addr", mem_addr, {a[31:2], 2'b00});
            if (resp_valid) lat = c;
        end
        req_valid = 1'b0;
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("busy_cycles", 32'(nbusy), 32'(exp_lat - 1));
        chk("read_cycles", 32'(nrd), 32'(exp_rd));
        chk("write_cycles", 32'(nwr), 32'(exp_wr));
        chk("misaligned", 32'(misaligned), 32'(flt));
        if (!flt && !wr) exp_rdata = exp_load;
        chk("resp_rdata", resp_rdata, exp_rdata);
        if (!flt && wr) begin
            model_store(sz, a, wd);
            chk("mem_word", env_mem[a[5:2]], ref_word(int'(a[5:2])));
        end
        rd = resp_rdata;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        exp_rdata = 32'h0;
        #1;
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_resp_valid", 32'(resp_valid), 32'h0);
        chk("rst_mem_strobes", 32'({mem_read, mem_write, misaligned}), 32'h0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;

        // Word store then load.
        do_op(1, 2'd2, 0, 32'd0, 32'h0000ABCD, 0, got);
        do_op(0, 2'd2, 0, 32'd0, 32'h0, 0, got);
        chk("lw0", got, 32'h0000ABCD);

        // Byte read-modify-write and extension.
        do_op(1, 2'd2, 0, 32'd4, 32'h12345678, 0, got);
        do_op(1, 2'd0, 0, 32'd5, 32'hFFFFFFEF, 0, got);
        do_op(0, 2'd2, 0, 32'd4, 32'h0, 0, got);
        chk("lw4", got, 32'h1234EF78);
        do_op(0, 2'd0, 0, 32'd5, 32'h0, 0, got);
        chk("lb5", got, 32'hFFFFFFEF);
        do_op(0, 2'd0, 1, 32'd5, 32'h0, 0, got);
        chk("lbu5", got, 32'h000000EF);
        do_op(0, 2'd1, 0, 32'd6, 32'h0, 0, got);
        chk("lh6", got, 32'h00001234);
        do_op(1, 2'd1, 0, 32'd6, 32'h0000BEEF, 0, got);
        do_op(0, 2'd1, 0, 32'd6, 32'h0, 0, got);
        chk("lh6_after_sh", got, 32'hFFFFBEEF);

        // Faults: no memory access, data held.
        do_op(0, 2'd1, 0, 32'd1, 32'h0, 0, got);
        do_op(0, 2'd2, 0, 32'd2, 32'h0, 0, got);
        do_op(1, 2'd3, 0, 32'd0, 32'h55, 0, got);
        chk("fault_holds_rdata", got, 32'hFFFFBEEF);

        // Reset during RMW_RD aborts the store.
        do_op(1, 2'd2, 0, 32'd8, 32'h12345678, 0, got);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'd8; req_wdata = 32'h0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("abort_in_rmw_rd", 32'({busy, mem_read}), 32'h3);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_strobes", 32'({resp_valid, misaligned, mem_read, mem_write}), 32'h0);
        chk("abort_resp_rdata", resp_rdata, 32'h0);
        chk("abort_mem_addr", mem_addr, 32'h0);
        chk("abort_mem_wdata", mem_wdata, 32'h0);
        exp_rdata = 32'h0;
        repeat (2) begin
            @(negedge clk);
            chk("abort_no_write", 32'(mem_write), 32'h0);
        end
        rst = 1'b0;
        do_op(0, 2'd2, 0, 32'd8, 32'h0, 0, got);
        chk("lw8_after_abort", got, 32'h12345678);

        // Stall: differing requests held high while busy.
        do_op(1, 2'd0, 0, 32'd13, 32'h000000A5, 1, got);
        do_op(0, 2'd0, 1, 32'd13, 32'h0, 1, got);
        chk("stall_lbu13", got, 32'h000000A5);

        // Random traffic.
        for (int k = 0; k < 80; k++) begin
            do_op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  32'($urandom_range(0, 63)), $urandom, 1'($urandom_range(0, 1)), got);
        end
        for (int w = 0; w < 16; w++) chk("final_mem", env_mem[w], ref_word(w));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Sub-word load/store controller between the datapath and the word-wide `DataMemory`. It accepts one load or store per request (byte, halfword or word; signed or unsigned loads) and drives `DataMemory`'s `Address`/`DataIn`/`MemRead`/`MemWrite`. Sub-word stores are done as read-modify-write. It stalls the core via `busy` and returns sign- or zero-extended load data with a one-cycle `resp_valid` pulse.

## Interface
- No parameters. Data and address widths are fixed at 32.
- `clk` in 1: rising-edge clock, shared with `DataMemory`.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request strobe. Sampled only while `busy`=0.
- `req_write` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 = byte, 01 = half, 10 = word, 11 = illegal.
- `req_unsigned` in 1: loads only. 1 = zero-extend, 0 = sign-extend.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, taken from the low bits for sub-word stores.
- `busy` out 1: high when state ≠ IDLE. The core must stall.
- `resp_valid` out 1: one-cycle completion pulse, registered.
- `resp_rdata` out 32: extended load result, registered. Holds its value after stores and faults.
- `misaligned` out 1: one-cycle fault pulse, coincident with `resp_valid`.
- `mem_addr` out 32: to `DataMemory.Address`. Always word-aligned: {addr[31:2],2'b00}.
- `mem_wdata` out 32: to `DataMemory.DataIn`.
- `mem_read` out 1: to `DataMemory.MemRead`.
- `mem_write` out 1: to `DataMemory.MemWrite`.
- `mem_rdata` in 32: from `DataMemory.DataOut`. The read is combinational and valid in the same cycle as `mem_addr`/`mem_read`.

## Operation
- Byte order is little-endian.
  - Byte lane k = addr[1:0] occupies bits [8k+7:8k].
  - Half lane = addr[1] occupies bits [16·addr[1]+15 : 16·addr[1]].
- Alignment rules:
  - Half requires addr[0]=0.
  - Word requires addr[1:0]=0.
  - Size 11 is always a fault.
- States: IDLE, LOAD, STORE, RMW_RD, RMW_WR.
- IDLE, on `req_valid`: latch addr, wdata, size, unsigned.
  - Fault: stay in IDLE, make no memory access. Next cycle `resp_valid`=1 and `misaligned`=1.
  - Load: go to LOAD.
  - Word store: go to STORE.
  - Byte/half store: go to RMW_RD.
- LOAD: `mem_read`=1. At the clock edge, register the extracted lane into `resp_rdata`, then go to IDLE.
- STORE: `mem_write`=1, `mem_wdata` = latched wdata. `DataMemory` writes at the edge; then go to IDLE.
- RMW_RD: `mem_read`=1. At the edge, capture the merged word (`mem_rdata` with the target lane replaced by wdata[7:0] or wdata[15:0]), then go to RMW_WR.
- RMW_WR: `mem_write`=1, `mem_wdata` = merged word. At the edge, go to IDLE.
- Every transition into IDLE from a non-IDLE state sets `resp_valid`=1 for the following cycle.
- `mem_read` and `mem_write` are decoded from state only. They are never both high. Both are 0 in IDLE.
- `req_valid` while `busy`=1 is ignored; no queueing.

## Timing
- Reset, asynchronous:
  - State → IDLE.
  - `busy`, `resp_valid`, `misaligned`, `mem_read`, `mem_write` all 0.
  - `resp_rdata`, `mem_addr`, `mem_wdata`, and all latches set to 0.
  - Takes effect immediately, mid-operation.
  - Reset during RMW_RD leaves memory untouched.
  - Reset during STORE or RMW_WR before the edge aborts the write: `mem_write` drops combinationally.
- Edge counts below are relative to accept edge E0.
- Load: LOAD during E0→E1. `resp_valid` and data are valid E1→E2. `busy` is high for 1 cycle.
- Word store: same timing as a load.
- Sub-word store: RMW_RD during E0→E1, RMW_WR during E1→E2, `resp_valid` E2→E3. `busy` is high for 2 cycles.
- Fault: `resp_valid`/`misaligned` E0→E1. `busy` stays 0.
- A new request can be accepted in the same cycle that `resp_valid` is high, giving back-to-back loads with 1 bubble.

## Test plan
- Word store then load:
  - sw 0x0000ABCD @0 → `mem_write` for 1 cycle with `mem_addr`=0.
  - lw @0 → `resp_rdata`=0x0000ABCD after 2 edges.
- Byte RMW:
  - sw 0x12345678 @4, then sb 0xEF @5 → exactly one `mem_read` cycle then one `mem_write` cycle.
  - lw @4 → 0x1234EF78.
- Load extension after the byte RMW:
  - lb @5 → 0xFFFFFFEF; lbu @5 → 0x000000EF.
  - lh @6 → 0x00001234.
  - sh 0xBEEF @6 then lh @6 → 0xFFFFBEEF.
- Faults:
  - lh @1, lw @2, size=11 @0 → each gives a `misaligned`+`resp_valid` pulse next cycle, `mem_read`/`mem_write` never asserted, `resp_rdata` unchanged.
- Reset abort: sw 0x12345678 @8, then sb 0x00 @8 with `rst` pulsed during RMW_RD → all outputs return to 0 immediately, `mem_write` never asserted, lw @8 → 0x12345678.
- Stall: assert `req_valid` continuously with differing requests during `busy` → only the first request (accepted in IDLE) executes; requests held during busy are ignored.
